// File: rtl/p_pkg.sv
// p_pkg: shared constants for the AEAD formatter (FSM codes, block size, padding mask).
// Byte order is little-endian throughout: byte 0 of any 128-bit word sits in bits [7:0].
package p_pkg;
  localparam int BLK = 16;
  localparam logic [31:0] PAD_MASK = 32'hFFFF_FFF0;
  localparam logic [3:0] S_IDLE = 4'd0;
  localparam logic [3:0] S_KEYR = 4'd1;
  localparam logic [3:0] S_KEYS = 4'd2;
  localparam logic [3:0] S_AAD  = 4'd3;
  localparam logic [3:0] S_CT   = 4'd4;
  localparam logic [3:0] S_LEN  = 4'd5;
  localparam logic [3:0] S_DONE = 4'd6;
  function automatic logic [31:0] pad16(input logic [31:0] x);
    return (x + 32'd15) & PAD_MASK;
  endfunction
endpackage

// File: rtl/p_byte_mask.sv
// p_byte_mask: byte keep-mask for a 16-byte word; rem_i bytes kept from byte 0 up, rem_i>=16 keeps all.
// Ports: rem_i (remaining byte count), mask_o (128-bit keep mask).
module p_byte_mask
  import p_pkg::*;
(
  input  logic [4:0]   rem_i,
  output logic [127:0] mask_o
);
  for (genvar k = 0; k < BLK; k++) begin : g_b
    assign mask_o[8*k +: 8] = (rem_i > 5'(k)) ? 8'hFF : 8'h00;
  end
endmodule

// File: rtl/p_aead_fmt.sv
// p_aead_fmt: formats r, s, padded AAD, padded CT and the length block for the Poly1305 tag engine.
// Ports: i_start/i_otk/i_len_* load a job; o_rqst_data/o_src_sel/i_vld_data/i_data fetch source words;
// o_start/o_len_msg announce the job; i_rqst_msg/o_en_msg/o_msg hand over words; o_done ends the job.
module p_aead_fmt
  import p_pkg::*;
#(
  parameter int LEN_W = 32
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_start,
  input  logic [255:0]     i_otk,
  input  logic [LEN_W-1:0] i_len_aad,
  input  logic [LEN_W-1:0] i_len_ct,
  output logic             o_rqst_data,
  output logic             o_src_sel,
  input  logic             i_vld_data,
  input  logic [127:0]     i_data,
  output logic             o_start,
  output logic [31:0]      o_len_msg,
  input  logic             i_rqst_msg,
  output logic             o_en_msg,
  output logic [127:0]     o_msg,
  output logic             o_done
);
  logic [3:0] state_q, state_d;
  logic [255:0] otk_q, otk_d;
  logic [LEN_W-1:0] aad_q, aad_d, ct_q, ct_d, rem_q, rem_d, take;
  logic [31:0] len_q, len_d;
  logic [127:0] msg_q, msg_d, keep;
  logic pend_q, pend_d, start_q, start_d, en_q, en_d, rqst_q, rqst_d, sel_q, sel_d, done_q, done_d;
  logic last;
  // A word is the stream's last when no more than one block of bytes remains.
  assign last = rem_q <= LEN_W'(BLK);
  assign take = last ? rem_q : LEN_W'(BLK);
  p_byte_mask u_mask (.rem_i(take[4:0]), .mask_o(keep));
  always_comb begin
    state_d = state_q;
    otk_d   = otk_q;
    aad_d   = aad_q;
    ct_d    = ct_q;
    rem_d   = rem_q;
    len_d   = len_q;
    pend_d  = pend_q;
    sel_d   = sel_q;
    msg_d   = msg_q;
    start_d = 1'b0;
    en_d    = 1'b0;
    rqst_d  = 1'b0;
    done_d  = 1'b0;
    case (state_q)
      S_IDLE: if (i_start) begin
        state_d = S_KEYR;
        otk_d   = i_otk;
        aad_d   = i_len_aad;
        ct_d    = i_len_ct;
        len_d   = pad16(32'(i_len_aad)) + pad16(32'(i_len_ct)) + 32'(BLK);
        start_d = 1'b1;
      end
      S_KEYR: if (i_rqst_msg) begin
        en_d    = 1'b1;
        msg_d   = otk_q[127:0];
        state_d = S_KEYS;
      end
      S_KEYS: if (i_rqst_msg) begin
        en_d    = 1'b1;
        msg_d   = otk_q[255:128];
        state_d = (aad_q != '0) ? S_AAD : (ct_q != '0) ? S_CT : S_LEN;
        rem_d   = (aad_q != '0) ? aad_q : ct_q;
      end
      S_AAD, S_CT: begin
        // While a source request is outstanding only i_vld_data matters; a colliding i_rqst_msg is dropped.
        if (pend_q) begin
          if (i_vld_data) begin
            en_d    = 1'b1;
            pend_d  = 1'b0;
            msg_d   = i_data & keep;
            rem_d   = last ? ct_q : rem_q - take;
            state_d = !last ? state_q : (state_q == S_AAD && ct_q != '0) ? S_CT : S_LEN;
          end
        end else if (i_rqst_msg) begin
          rqst_d = 1'b1;
          pend_d = 1'b1;
          sel_d  = state_q == S_CT;
        end
      end
      S_LEN: if (i_rqst_msg) begin
        en_d    = 1'b1;
        msg_d   = {32'd0, 32'(ct_q), 32'd0, 32'(aad_q)};
        state_d = S_DONE;
      end
      S_DONE: begin
        done_d  = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q <= S_IDLE;
      otk_q   <= '0;
      aad_q   <= '0;
      ct_q    <= '0;
      rem_q   <= '0;
      len_q   <= '0;
      pend_q  <= 1'b0;
      sel_q   <= 1'b0;
      msg_q   <= '0;
      start_q <= 1'b0;
      en_q    <= 1'b0;
      rqst_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      otk_q   <= otk_d;
      aad_q   <= aad_d;
      ct_q    <= ct_d;
      rem_q   <= rem_d;
      len_q   <= len_d;
      pend_q  <= pend_d;
      sel_q   <= sel_d;
      msg_q   <= msg_d;
      start_q <= start_d;
      en_q    <= en_d;
      rqst_q  <= rqst_d;
      done_q  <= done_d;
    end
  end
  assign o_rqst_data = rqst_q;
  assign o_src_sel   = sel_q;
  assign o_start     = start_q;
  assign o_len_msg   = len_q;
  assign o_en_msg    = en_q;
  assign o_msg       = msg_q;
  assign o_done      = done_q;
endmodule

// File: doc/p_aead_fmt.md
Name: p_aead_fmt

Overview:
- Upstream feeder of the Poly1305 tag engine in the ChaCha20-Poly1305 AEAD path.
- Takes the 256-bit one-time key from ChaCha20 block 0, plus AAD and ciphertext streams from the data source.
- Emits, one 128-bit word per tag-engine request pulse, this sequence: r, s, AAD (zero-padded to 16 B), CT (zero-padded to 16 B), length block.
- Computes the padded total message length handed to the tag engine at start.

Parameters:
- LEN_W, 32, width of AAD/CT byte-length inputs.

Ports:
- i_clk  in  1  clock; single clock domain.
- i_rst  in  1  reset, synchronous, active-high.
- i_start  in  1  one-cycle pulse; latches key and lengths; ignored unless IDLE.
- i_otk  in  256  one-time key; [127:0]=r (unclamped), [255:128]=s.
- i_len_aad  in  LEN_W  AAD byte count.
- i_len_ct  in  LEN_W  CT byte count.
- o_rqst_data  out  1  one-cycle pulse requesting the next 16-byte source word.
- o_src_sel  out  1  0=AAD stream, 1=CT stream; valid while a request is outstanding.
- i_vld_data  in  1  source word valid pulse.
- i_data  in  128  source word; byte k at bits [8k+7:8k].
- o_start  out  1  start pulse to tag engine.
- o_len_msg  out  32  padded message length to tag engine.
- i_rqst_msg  in  1  tag-engine word request pulse.
- o_en_msg  out  1  word-valid pulse to tag engine.
- o_msg  out  128  word to tag engine.
- o_done  out  1  one-cycle pulse after the length block is sent.

Behaviour:
- Reset: all outputs 0, FSM=IDLE, counters 0. Reset mid-operation aborts immediately with no further pulses.
- Lengths: pad16(x) = (x+15) & ~15. o_len_msg = pad16(aad) + pad16(ct) + 16, truncated to 32 bits. Captured in the i_start cycle and held until the next start.
- Start: o_start pulses the cycle after i_start, with o_len_msg valid in that same cycle.
- FSM states: IDLE, KEYR, KEYS, AAD, CT, LEN, DONE.
  - IDLE -(i_start)-> KEYR.
  - KEYR: on i_rqst_msg, o_en_msg=1 and o_msg=r the next cycle -> KEYS.
  - KEYS: on i_rqst_msg, sends s -> AAD if aad>0, else CT if ct>0, else LEN.
- AAD/CT word flow:
  - On i_rqst_msg, pulse o_rqst_data next cycle with o_src_sel set, then wait.
  - On i_vld_data, register the masked word; o_en_msg pulses the following cycle.
  - Decrement the remaining-byte counter by min(16, rem).
  - When rem reaches 0, go AAD->CT (LEN if ct=0), or CT->LEN.
- Mask: final partial word keeps bytes [rem-1:0] and zeroes the rest. Full words pass unchanged.
- LEN: on i_rqst_msg, send {32'd0, ct, 32'd0, aad} (aad in bits [63:0], ct in bits [127:64]) -> DONE.
- DONE: o_done pulses one cycle -> IDLE.
- Latency:
  - Key and length words: i_rqst_msg to o_en_msg is 1 cycle.
  - Data words: i_rqst_msg to o_rqst_data is 1 cycle; i_vld_data to o_en_msg is 1 cycle.
- Ignored events:
  - i_rqst_msg while a source request is outstanding, or in IDLE/DONE.
  - i_vld_data with no outstanding request.
  - i_start when not IDLE.
- Simultaneous i_rqst_msg and i_vld_data: i_vld_data is serviced; the request is dropped (protocol violation).
- o_en_msg and o_rqst_data never assert in the same cycle.

Decomposition:
- Shared package p_pkg:
  - FSM state encodings (4-bit).
  - PAD_MASK = 32'hFFFF_FFF0.
  - Block size constant 16.
  - Byte-order convention: little-endian, byte 0 in the LSBs.
- Sub-module p_byte_mask (combinational): 5-bit remaining count in, 128-bit keep mask out; rem ≥16 gives all-ones.

Test Plan:
- RFC 8439 §2.8.2 vector, aad=12, ct=114:
  - o_len_msg=160.
  - Exactly 12 o_en_msg pulses in order r, s, 1 AAD, 8 CT, len.
  - Len word = 128'h00000000_00000072_00000000_0000000C.
  - Cascaded tag engine yields 1ae10b594f09e26a7e902ecbd0600691.
- aad=0, ct=0: o_len_msg=16; no o_rqst_data ever; words are r, s, all-zero len block; then o_done.
- aad=16, ct=17 with source driving all-FF words:
  - o_len_msg=64.
  - AAD word all FF.
  - CT words: all FF, then 128'h...00FF (byte 0 only).
  - o_src_sel is 0, then 1, 1.
- Source replies 5 cycles late: o_en_msg pulses exactly 1 cycle after i_vld_data; extra i_rqst_msg during the wait is ignored; a spurious i_vld_data in IDLE produces no output.
- i_rst asserted while in CT:
  - Next cycle all outputs are 0 and FSM=IDLE.
  - A fresh i_start then runs a complete sequence correctly.
- Second i_start during KEYS is ignored; o_len_msg is unchanged and the sequence completes normally.
